// File: rtl/zd_pkg.sv
// Shared definitions for the zero_detect block: default sizes, a constant clog2 and the run
// counter type.
package zd_pkg;

  localparam int unsigned WIDTH_DFLT     = 4;
  localparam int unsigned CNT_WIDTH_DFLT = 8;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < value) begin
      r++;
    end
    return r;
  endfunction

  localparam int unsigned LZC_W = clog2(WIDTH_DFLT + 1);

  typedef logic [CNT_WIDTH_DFLT-1:0] run_cnt_t;

endpackage

// File: rtl/zd_lzc.sv
// Tree leading-zero counter, MSB first; an all-zero input yields WIDTH. Non-power-of-two widths
// are zero-padded on the LSB side and the result clamped back to WIDTH.
module zd_lzc
  import zd_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic [WIDTH-1:0]           in_i,
  output logic [$clog2(WIDTH+1)-1:0] lzc_o
);

  localparam int unsigned P    = 32'd1 << clog2(WIDTH);
  localparam int unsigned OutW = $clog2(WIDTH + 1);

  if (P == 1) begin : g_leaf
    assign lzc_o = ~in_i[0];
  end else begin : g_node
    localparam int unsigned H  = P / 2;
    localparam int unsigned HW = $clog2(H + 1);
    localparam int unsigned PW = $clog2(P + 1);

    logic [P-1:0]  padded;
    logic [HW-1:0] hi_cnt;
    logic [HW-1:0] lo_cnt;
    logic [PW-1:0] cnt_p;

    assign padded = P'(in_i) << (P - WIDTH);

    zd_lzc #(
      .WIDTH(H)
    ) u_hi (
      .in_i (padded[P-1:H]),
      .lzc_o(hi_cnt)
    );

    zd_lzc #(
      .WIDTH(H)
    ) u_lo (
      .in_i (padded[H-1:0]),
      .lzc_o(lo_cnt)
    );

    // Only when the upper half is all zero does the lower half contribute.
    assign cnt_p = (hi_cnt == HW'(H)) ? PW'(H) + PW'(lo_cnt) : PW'(hi_cnt);
    assign lzc_o = (cnt_p > PW'(WIDTH)) ? OutW'(WIDTH) : OutW'(cnt_p);
  end

endmodule

// File: rtl/zero_detect.sv
// All-zero word detector with a registered flag and a saturating zero-run counter.
// Define ZD_LZC_EN to add the combinational leading-zero count output lzc.
module zero_detect
  import zd_pkg::*;
#(
  parameter int unsigned WIDTH     = WIDTH_DFLT,
  parameter int unsigned CNT_WIDTH = CNT_WIDTH_DFLT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WIDTH-1:0]     In,
  output logic                 Out,
  output logic                 out_q,
  output logic [CNT_WIDTH-1:0] run_cnt,
  output logic                 run_sat
`ifdef ZD_LZC_EN
  ,
  output logic [$clog2(WIDTH+1)-1:0] lzc
`endif
);

  localparam logic [CNT_WIDTH-1:0] CntMax = {CNT_WIDTH{1'b1}};

  logic                 zero;
  logic                 zero_d, zero_q;
  logic [CNT_WIDTH-1:0] run_cnt_d, run_cnt_q;

  assign zero = ~|In;
  assign Out  = zero;

  always_comb begin
    zero_d    = zero;
    run_cnt_d = '0;
    if (zero) begin
      run_cnt_d = (run_cnt_q == CntMax) ? CntMax : run_cnt_q + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      zero_q    <= 1'b0;
      run_cnt_q <= '0;
    end else begin
      zero_q    <= zero_d;
      run_cnt_q <= run_cnt_d;
    end
  end

  assign out_q   = zero_q;
  assign run_cnt = run_cnt_q;
  assign run_sat = &run_cnt_q;

`ifdef ZD_LZC_EN
  zd_lzc #(
    .WIDTH(WIDTH)
  ) u_lzc (
    .in_i (In),
    .lzc_o(lzc)
  );
`endif

endmodule

// File: tb/tb_zero_detect.sv
// Randomized scoreboard bench for zero_detect against a run-length reference model.
module tb_zero_detect;

  localparam int W   = 4;
  localparam int CW  = 2;
  localparam int MAX = (1 << CW) - 1;

  logic          clk;
  logic          rst;
  logic [W-1:0]  In;
  logic          Out;
  logic          out_q;
  logic [CW-1:0] run_cnt;
  logic          run_sat;
`ifdef ZD_LZC_EN
  logic [$clog2(W+1)-1:0] lzc;
`endif

  zero_detect #(
    .WIDTH    (W),
    .CNT_WIDTH(CW)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .In     (In),
    .Out    (Out),
    .out_q  (out_q),
    .run_cnt(run_cnt),
    .run_sat(run_sat)
`ifdef ZD_LZC_EN
    ,
    .lzc    (lzc)
`endif
  );

  typedef struct {
    bit out;
    bit out_q;
    int cnt;
    bit sat;
    int lzc;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  int   zrun  = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int ref_lzc(input logic [W-1:0] v);
    int n = 0;
    bit found = 0;
    for (int i = W - 1; i >= 0; i--) begin
      if (!found && !v[i]) n++;
      else found = 1;
    end
    return n;
  endfunction

  task automatic check_comb(input string name);
    chk({name, "_out"}, int'(Out), int'(In == '0));
`ifdef ZD_LZC_EN
    chk({name, "_lzc"}, int'(lzc), ref_lzc(In));
`endif
  endtask

  // Drive one sample between edges and queue what the next edge must produce.
  task automatic step(input logic [W-1:0] v);
    exp_t e;
    @(negedge clk);
    rst = 1'b0;
    In  = v;
    zrun     = (v == '0) ? zrun + 1 : 0;
    e.out    = (v == '0);
    e.out_q  = (v == '0);
    e.cnt    = (zrun > MAX) ? MAX : zrun;
    e.sat    = (zrun >= MAX);
    e.lzc    = ref_lzc(v);
    sb.push_back(e);
  endtask

  task automatic async_reset(input string name);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk({name, "_out_q"}, int'(out_q), 0);
    chk({name, "_cnt"}, int'(run_cnt), 0);
    chk({name, "_sat"}, int'(run_sat), 0);
    check_comb(name);
    zrun = 0;
  endtask

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk("out", int'(Out), int'(e.out));
      chk("out_q", int'(out_q), int'(e.out_q));
      chk("run_cnt", int'(run_cnt), e.cnt);
      chk("run_sat", int'(run_sat), int'(e.sat));
`ifdef ZD_LZC_EN
      chk("lzc", int'(lzc), e.lzc);
`endif
    end
  end

  initial begin
    logic [W-1:0] comb_seq [5];
    logic [W-1:0] v;
    comb_seq = '{4'h0, 4'h1, 4'h2, 4'h4, 4'h8};
    rst = 1'b1;
    In  = '0;
    #1;
    chk("rst_out_q", int'(out_q), 0);
    chk("rst_cnt", int'(run_cnt), 0);
    chk("rst_sat", int'(run_sat), 0);
    chk("rst_out", int'(Out), 1);

    // Combinational path while held in reset: registers stay frozen.
    for (int i = 0; i < 5; i++) begin
      In = comb_seq[i];
      #1;
      check_comb("comb");
      #9;
    end
    chk("rst_hold_cnt", int'(run_cnt), 0);

    for (int i = 0; i < 5; i++) step('0);
    step(4'h2);
    for (int i = 0; i < 6; i++) step('0);
    step(4'h3);
    for (int i = 0; i < 4; i++) step('0);
    async_reset("midrun_rst");
    for (int i = 0; i < 3; i++) step('0);
    step(4'h1);

    for (int n = 0; n < 400; n++) begin
      v = ($urandom_range(0, 2) == 0) ? W'($urandom) : '0;
      step(v);
      if ($urandom_range(0, 50) == 0) async_reset("rand_rst");
    end

    @(posedge clk);
    #3;
    chk("sb_drain", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
